// File: rtl/apb_waitstate_slave.sv
// rtl/apb_waitstate_slave.sv - APB completer with register bank, programmable wait states and error response
// STATUS (top slot) counts successful writes; out-of-range and STATUS writes answer with PSLVERR.
module apb_waitstate_slave #(
    parameter int WIDTH       = 7,
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0]      pwdata,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [WIDTH-1:0]      prdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] STATUS_W = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [3:0]          WAIT_W   = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      regs_q [DEPTH-1];
    logic [WIDTH-1:0]      status_q;

    logic             addr_err;
    logic             is_status;
    logic             resp_err;
    logic             commit;
    logic [WIDTH-1:0] reg_val;

    // Decode works only on the setup-phase latch; access-phase bus changes are ignored.
    assign addr_err  = {1'b0, addr_q} >= DEPTH_W;
    assign is_status = {1'b0, addr_q} == STATUS_W;
    assign resp_err  = addr_err | (write_q & is_status);
    assign commit    = (state_q == S_READY) & write_q & ~resp_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = paddr;
                    write_d = PWRITE;
                    wdata_d = pwdata;
                    cnt_d   = WAIT_W;
                    state_d = (WAIT_W != 4'd0) ? S_WAIT : S_READY;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        reg_val = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) begin
                reg_val = regs_q[i];
            end
        end
    end

    always_comb begin
        PREADY  = (state_q == S_READY);
        PSLVERR = PREADY & resp_err;
        prdata  = '0;
        if (PREADY && !resp_err) begin
            prdata = is_status ? status_q : reg_val;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            status_q <= '0;
            for (int i = 0; i < DEPTH - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (commit && addr_q == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= wdata_q;
                end
            end
            if (commit) begin
                status_q <= status_q + WIDTH'(1);
            end
        end
    end

endmodule
